packetizer_arbiter: RTL

PACKETIZER_ARBITER -- requirements
Module: packetizer_arbiter

---
 rtl/packetizer_pkg.sv | 37 +++
 rtl/packetizer_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/packetizer_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/packetizer_pkg.sv
// Shared definitions for the packetizer arbiter.
//
// Purpose: flit field-width helpers and header bit positions used by the
// top level formatter. A flit occupies the lower half of the NoC port:
//   [H-1] valid, [H-2] head, [H-3] tail, then VC, dst, payload (+ zero pad).
//
// Contents:
//   HDR_BITS, VALID_OFS, HEAD_OFS, TAIL_OFS : header layout (bit = H - ofs)
//   flit_half()    : H, the used half of the port
//   payload_bits() : P, payload field width
//   payload_used() : A, requester bits that fit in the payload field
//   pad_bits()     : P - A, zero padding below the payload
package packetizer_pkg;

  localparam int HDR_BITS  = 3;
  localparam int VALID_OFS = 1;
  localparam int HEAD_OFS  = 2;
  localparam int TAIL_OFS  = 3;

  function automatic int flit_half(input int width_out);
    return width_out / 2;
  endfunction

  function automatic int payload_bits(input int width_out, input int addr_w,
                                      input int vc_w);
    return flit_half(width_out) - HDR_BITS - addr_w - vc_w;
  endfunction

  function automatic int payload_used(input int p, input int width_in);
    return (p < width_in) ? p : width_in;
  endfunction

  function automatic int pad_bits(input int p, input int width_in);
    return p - payload_used(p, width_in);
  endfunction

endpackage

// File: rtl/packetizer_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//
// Purpose: picks the first requesting port at or after the pointer,
// wrapping from NUM_REQ-1 to 0. The pointer moves to winner+1 only when a
// grant is actually taken (advance high and some request present).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-port request bits
//   advance    : the granted request is consumed this cycle
//   grant      : one-hot winner (zero if no request)
//   grant_idx  : binary index of the winner (0 if no request)
//   ptr        : current round-robin pointer (state, exposed for observation)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic [PTR_W-1:0]   ptr
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ must be in 2..16");
  end

  logic found;

  // Scan NUM_REQ positions starting at ptr; first hit wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/packetizer_arbiter.sv
// Packetizer arbiter: N requesters -> one NoC port.
//
// Purpose: round-robin selects one valid requester, formats its payload and
// destination into a single head/tail flit and loads it into a 1-entry
// output register.
//
// Handshake: every port transfers when valid and ready are both high in the
// same cycle; a valid source holds its data until accepted. The output
// register loads whenever it is empty or being drained (!valid_out |
// ready_in), so a drain and a refill can happen in the same cycle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : NUM_REQ payloads, requester i at [i*WIDTH_IN +: WIDTH_IN]
//   valid_in   : per-requester valid
//   dst_in     : NUM_REQ destinations, requester i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   ready_out  : per-requester accept (one-hot or zero)
//   data_out   : registered flit
//   valid_out  : flit valid
//   ready_in   : NoC backpressure
module packetizer_arbiter
  import packetizer_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_OUT        = 36,
  parameter int ASSIGNED_VC      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*WIDTH_IN-1:0]       data_in,
  input  logic [NUM_REQ-1:0]                valid_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  dst_in,
  output logic [NUM_REQ-1:0]                ready_out,
  output logic [WIDTH_OUT-1:0]              data_out,
  output logic                              valid_out,
  input  logic                              ready_in
);

  localparam int H     = flit_half(WIDTH_OUT);
  localparam int P     = payload_bits(WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int A     = payload_used(P, WIDTH_IN);
  localparam int PAD   = pad_bits(P, WIDTH_IN);
  localparam int PW    = (P < 1) ? 1 : P;
  localparam int PTR_W = $clog2(NUM_REQ);

  logic                     load;
  logic                     accept;
  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         ptr;
  logic [WIDTH_IN-1:0]      sel_data;
  logic [ADDRESS_WIDTH-1:0] sel_dst;
  logic [PW-1:0]            payload;
  logic [WIDTH_OUT-1:0]     flit;

  assign load = !valid_out || ready_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (valid_in),
    .advance   (load),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (ptr)
  );

  // Gated by rst_n so no accept is signalled while reset is held,
  // whatever the requesters drive.
  assign ready_out = grant & {NUM_REQ{load & rst_n}};
  assign accept    = |ready_out;

  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = data_in[i*WIDTH_IN +: WIDTH_IN];
        sel_dst  = dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  // Payload keeps the most significant A bits; narrower inputs are
  // left-aligned with zero padding below.
  if (P < 1) begin : g_bad_payload
    $error("packetizer_arbiter: no room for payload in the flit");
    assign payload = '0;
  end else if (PAD > 0) begin : g_padded
    assign payload = {sel_data[WIDTH_IN-1 -: A], {PAD{1'b0}}};
  end else begin : g_truncated
    assign payload = sel_data[WIDTH_IN-1 -: A];
  end

  always_comb begin
    flit                = '0;
    flit[H - VALID_OFS] = 1'b1;
    flit[H - HEAD_OFS]  = 1'b1;
    flit[H - TAIL_OFS]  = 1'b1;
    flit[H-HDR_BITS-1 -: VC_ADDRESS_WIDTH] = VC_ADDRESS_WIDTH'(ASSIGNED_VC);
    flit[H-HDR_BITS-VC_ADDRESS_WIDTH-1 -: ADDRESS_WIDTH] = sel_dst;
    flit[PW-1:0]        = payload;
  end

  // data_out only changes on an accept so it holds its last flit while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= accept;
      if (accept) data_out <= flit;
    end
  end

endmodule
